// File: rtl/leg_fetch_unit_if.sv
// Bus bundle between the LEG fetch unit, its program memory and the decode stage.
// The master side belongs to the fetch unit; the slave side is the memory/decode environment.
interface leg_fetch_unit_if #(
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] mem_addr;
    logic                mem_rd;
    logic [7:0]          mem_data;
    logic [7:0]          instr_opcode;
    logic [7:0]          instr_arg1;
    logic [7:0]          instr_arg2;
    logic [7:0]          instr_dest;
    logic [PC_WIDTH-1:0] instr_pc;
    logic                instr_valid;
    logic                instr_ready;
    logic                jump_valid;
    logic [PC_WIDTH-1:0] jump_target;

    modport master (
        output mem_addr, mem_rd,
        input  mem_data,
        output instr_opcode, instr_arg1, instr_arg2, instr_dest, instr_pc, instr_valid,
        input  instr_ready,
        input  jump_valid, jump_target
    );

    modport slave (
        input  mem_addr, mem_rd,
        output mem_data,
        input  instr_opcode, instr_arg1, instr_arg2, instr_dest, instr_pc, instr_valid,
        output instr_ready,
        output jump_valid, jump_target
    );
endinterface

// File: rtl/leg_fetch_unit.sv
// LEG instruction fetch: reads four bytes from a 1-cycle-latency byte memory,
// holds them for the decoder behind a valid/ready handshake, and redirects on jumps.
module leg_fetch_unit #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    leg_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t              state_q, state_nxt;
    logic [PC_WIDTH-1:0] pc_q, pc_nxt;
    logic [1:0]          idx_q, idx_nxt;
    logic [7:0]          opcode_q, arg1_q, arg2_q, dest_q;
    logic [PC_WIDTH-1:0] ipc_q;
    logic                accept;

    assign accept = (state_q == VALID) && bus.instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            idx_q   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        idx_nxt   = idx_q;
        case (state_q)
            FETCH: begin
                idx_nxt = idx_q + 2'd1;
                if (idx_q == 2'd3) state_nxt = DRAIN;
            end
            DRAIN: begin
                idx_nxt   = 2'd0;
                state_nxt = VALID;
            end
            VALID: begin
                if (accept) begin
                    pc_nxt    = pc_q + PC_WIDTH'(4);
                    idx_nxt   = 2'd0;
                    state_nxt = FETCH;
                end
            end
            default: begin
                idx_nxt   = 2'd0;
                state_nxt = FETCH;
            end
        endcase
        // A redirect overrides everything, including the pc+4 of a same-cycle accept.
        if (bus.jump_valid) begin
            pc_nxt    = bus.jump_target;
            idx_nxt   = 2'd0;
            state_nxt = FETCH;
        end
    end

    // The byte on mem_data belongs to the read issued with idx-1; idx=0 never captures,
    // which drops any read left in flight by a jump, accept or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q <= 8'd0;
            arg1_q   <= 8'd0;
            arg2_q   <= 8'd0;
            dest_q   <= 8'd0;
            ipc_q    <= RESET_PC;
        end else if (state_q == DRAIN) begin
            dest_q <= bus.mem_data;
            ipc_q  <= pc_q;
        end else if (state_q == FETCH) begin
            case (idx_q)
                2'd1:    opcode_q <= bus.mem_data;
                2'd2:    arg1_q   <= bus.mem_data;
                2'd3:    arg2_q   <= bus.mem_data;
                default: ;
            endcase
        end
    end

    assign bus.mem_rd       = (state_q == FETCH) && !rst;
    assign bus.mem_addr     = pc_q + PC_WIDTH'(idx_q);
    assign bus.instr_valid  = (state_q == VALID);
    assign bus.instr_opcode = opcode_q;
    assign bus.instr_arg1   = arg1_q;
    assign bus.instr_arg2   = arg2_q;
    assign bus.instr_dest   = dest_q;
    assign bus.instr_pc     = ipc_q;
endmodule
